// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    STAGE     = 2'd2,
    RUN       = 2'd3
  } pll_state_t;

  localparam int DEF_LOCK_WAIT = 16;
  localparam int DEF_STAGE_GAP = 8;
  localparam int DEF_CE_NUM    = 2;
  localparam int DEF_CE_DEN    = 25;
  localparam int DEF_CE_W      = 8;

  // Width of a down-counter that must hold max(a,b)-1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/frac_ce_gen.sv
// Fractional clock-enable generator: NUM strobes every DEN cycles while run is high.
// Also intended for the video-domain enable.
module frac_ce_gen
  import pll_seq_pkg::*;
#(
  parameter int NUM = DEF_CE_NUM,
  parameter int DEN = DEF_CE_DEN,
  parameter int W   = DEF_CE_W
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic ce
);

  logic [W-1:0] acc_reg;
  logic [W-1:0] sum;
  logic         wrap;

  assign sum  = acc_reg + W'(NUM);
  assign wrap = (sum >= W'(DEN));
  // Strobe is taken straight from the accumulator so it lines up with the wrap cycle.
  assign ce   = run && wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (!run) begin
      acc_reg <= '0;
    end else if (wrap) begin
      acc_reg <= sum - W'(DEN);
    end else begin
      acc_reg <= sum;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock sequencer: staged memory/CPU reset release and CPU clock-enable.
// Optional lock-loss counter on loss_cnt when PLL_LOSS_CNT_EN is defined.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int LOCK_WAIT = DEF_LOCK_WAIT,
  parameter int STAGE_GAP = DEF_STAGE_GAP,
  parameter int CE_NUM    = DEF_CE_NUM,
  parameter int CE_DEN    = DEF_CE_DEN,
  parameter int CE_W      = DEF_CE_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       rst_mem,
  output logic       rst_cpu,
  output logic       ce_cpu,
  output logic       ready
`ifdef PLL_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  localparam int CNT_W = cnt_width(LOCK_WAIT, STAGE_GAP);

  logic             sync1_reg;
  logic             lock_s_reg;
  pll_state_t       state_reg;
  pll_state_t       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             rst_mem_reg;
  logic             rst_cpu_reg;
  logic             ready_reg;
  logic             lock_lost;
  logic             ce_run;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lock_lost  = 1'b0;
    // Losing lock outranks every other transition.
    if (state_reg != WAIT_LOCK && !lock_s_reg) begin
      state_next = WAIT_LOCK;
      lock_lost  = 1'b1;
    end else begin
      case (state_reg)
        WAIT_LOCK: begin
          if (lock_s_reg) begin
            state_next = SETTLE;
            cnt_next   = CNT_W'(LOCK_WAIT - 1);
          end
        end
        SETTLE: begin
          if (cnt_reg == '0) begin
            state_next = STAGE;
            cnt_next   = CNT_W'(STAGE_GAP - 1);
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        STAGE: begin
          if (cnt_reg == '0) begin
            state_next = RUN;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        RUN:     state_next = RUN;
        default: state_next = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg   <= 1'b0;
      lock_s_reg  <= 1'b0;
      state_reg   <= WAIT_LOCK;
      cnt_reg     <= '0;
      rst_mem_reg <= 1'b1;
      rst_cpu_reg <= 1'b1;
      ready_reg   <= 1'b0;
    end else begin
      sync1_reg   <= locked;
      lock_s_reg  <= sync1_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rst_mem_reg <= !(state_next == STAGE || state_next == RUN);
      rst_cpu_reg <= (state_next != RUN);
      ready_reg   <= (state_next == RUN);
    end
  end

  assign rst_mem = rst_mem_reg;
  assign rst_cpu = rst_cpu_reg;
  assign ready   = ready_reg;
  assign ce_run  = (state_reg == RUN) && lock_s_reg;

  frac_ce_gen #(
    .NUM(CE_NUM),
    .DEN(CE_DEN),
    .W  (CE_W)
  ) u_ce_gen (
    .clk(clk),
    .rst(rst),
    .run(ce_run),
    .ce (ce_cpu)
  );

`ifdef PLL_LOSS_CNT_EN
  logic [7:0] loss_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt_reg <= 8'd0;
    end else if (lock_lost && loss_cnt_reg != 8'hFF) begin
      loss_cnt_reg <= loss_cnt_reg + 8'd1;
    end
  end

  assign loss_cnt = loss_cnt_reg;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: reference model expressed as lock-streak length.
module tb_pll_reset_seq;
  import pll_seq_pkg::*;

  localparam int LW    = 16;
  localparam int SG    = 8;
  localparam int CN    = 2;
  localparam int CD    = 25;
  localparam int RUN_H = LW + SG + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic locked = 1'b0;
  logic rst_mem, rst_cpu, ce_cpu, ready;
`ifdef PLL_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  pll_reset_seq #(
    .LOCK_WAIT(LW), .STAGE_GAP(SG), .CE_NUM(CN), .CE_DEN(CD), .CE_W(8)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked),
    .rst_mem(rst_mem), .rst_cpu(rst_cpu), .ce_cpu(ce_cpu), .ready(ready)
`ifdef PLL_LOSS_CNT_EN
    , .loss_cnt(loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] outs;
    int         loss;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Model state: two-sample lock pipeline, current lock streak, loss events.
  bit m_s1, m_s2;
  int m_h, m_loss;

  function automatic logic [3:0] model_outs(input int h, input bit ls);
    logic mem, cpu, rdy, ce;
    int   n;
    mem = (h < LW + 1);
    cpu = (h < RUN_H);
    rdy = !cpu;
    ce  = 1'b0;
    if (h >= RUN_H && ls) begin
      n  = h - RUN_H;
      ce = (((n + 1) * CN) / CD) != ((n * CN) / CD);
    end
    return {mem, cpu, rdy, ce};
  endfunction

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_h = 0; m_loss = 0;
  endtask

  task automatic step(input bit l, input bit r = 1'b0);
    exp_t e;
    @(negedge clk);
    #1;
    rst    = r;
    locked = l;
    @(posedge clk);
    cyc++;
    if (r) begin
      model_clear();
    end else begin
      if (m_s2) begin
        m_h++;
      end else begin
        if (m_h > 0 && m_loss < 255) m_loss++;
        m_h = 0;
      end
      m_s2 = m_s1;
      m_s1 = l;
    end
    e.cyc  = cyc;
    e.outs = r ? 4'b1100 : model_outs(m_h, m_s2);
    e.loss = m_loss;
    sb_q.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
  endtask

  // Monitor: DUT outputs are presented every cycle; compare against the queued model.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] got;
    bit         ok;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = {rst_mem, rst_cpu, ready, ce_cpu};
      ok  = (got === e.outs);
`ifdef PLL_LOSS_CNT_EN
      ok  = ok && (int'(loss_cnt) == e.loss);
`endif
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL outs cyc=%0d got(mem,cpu,rdy,ce)=%b exp=%b exp_loss=%0d",
                    e.cyc, got, e.outs, e.loss);
    end
  end

  task automatic async_rst_pulse();
    @(negedge clk);
    #2;
    rst = 1'b1;
    sb_q.delete();
    model_clear();
    #1;
    check("async_rst_outs", int'({rst_mem, rst_cpu, ready, ce_cpu}), 4'b1100);
`ifdef PLL_LOSS_CNT_EN
    check("async_rst_loss", int'(loss_cnt), 0);
`endif
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
  endtask

  // Steps with locked high until rst_mem falls; returns the edge index or -1.
  task automatic wait_mem_fall(output int edge_idx);
    edge_idx = -1;
    for (int i = 0; i < 60 && edge_idx < 0; i++) begin
      step(1'b1);
      #1;
      if (!rst_mem) edge_idx = cyc;
    end
  endtask

  initial begin
    int k, r_edge, mem_e, cpu_e, rdy_e, first_ce, run_idx, pulses, last, gmin, gmax, gap;

    #2 rst = 1'b1;
    #1;
    check("reset_outs", int'({rst_mem, rst_cpu, ready, ce_cpu}), 4'b1100);
`ifdef PLL_LOSS_CNT_EN
    check("reset_loss", int'(loss_cnt), 0);
`endif
    model_clear();
    repeat (3) step(1'b0, 1'b1);
    repeat (3) step(1'b0);

    // Power-up and rate check.
    step(1'b1);
    k = cyc;
    mem_e = -1; cpu_e = -1; rdy_e = -1; first_ce = -1;
    run_idx = 0; pulses = 0; last = -1; gmin = 9999; gmax = 0;
    for (int i = 0; i < 3000 && run_idx < 2500; i++) begin
      step(1'b1);
      #1;
      if (!rst_mem && mem_e < 0) mem_e = cyc;
      if (!rst_cpu && cpu_e < 0) cpu_e = cyc;
      if (ready && rdy_e < 0) rdy_e = cyc;
      if (ready) begin
        run_idx++;
        if (ce_cpu) begin
          pulses++;
          if (first_ce < 0) first_ce = run_idx;
          if (last >= 0) begin
            gap  = run_idx - last;
            gmin = (gap < gmin) ? gap : gmin;
            gmax = (gap > gmax) ? gap : gmax;
          end
          last = run_idx;
        end
      end
    end
    check("run_cycles_reached", run_idx, 2500);
    check("mem_release_edge", mem_e, k + LW + 2);
    check("cpu_release_edge", cpu_e, k + LW + SG + 2);
    check("ready_rise_edge", rdy_e, k + LW + SG + 2);
    check("first_ce_run_cycle", first_ce, (CD + CN - 1) / CN);
    check("ce_pulse_count", pulses, 2500 * CN / CD);
    check("ce_min_gap", gmin, CD / CN);
    check("ce_max_gap", gmax, (CD + CN - 1) / CN);
    $display("scenario power-up/rate done at cycle %0d", cyc);

    // Lock glitch in SETTLE.
    repeat (4) step(1'b0);
    step(1'b1);
    repeat (10) step(1'b1);
    step(1'b0);
    step(1'b1);
    r_edge = cyc;
    wait_mem_fall(mem_e);
    check("glitch_relock_mem_edge", mem_e, r_edge + LW + 2);
`ifdef PLL_LOSS_CNT_EN
    check("glitch_loss_cnt", int'(loss_cnt), 2);
`endif
    $display("scenario settle-glitch done at cycle %0d", cyc);

    // Lock loss in RUN, then relock.
    repeat (40) step(1'b1);
    repeat (3) step(1'b0);
    #1;
    check("run_loss_outs", int'({rst_mem, rst_cpu, ready, ce_cpu}), 4'b1100);
    repeat (70) step(1'b1);
    $display("scenario run-loss done at cycle %0d", cyc);

    // Async reset in the middle of STAGE, then a clean sequence.
    repeat (3) step(1'b0);
    repeat (LW + 6) step(1'b1);
    async_rst_pulse();
    step(1'b1);
    r_edge = cyc;
    wait_mem_fall(mem_e);
    check("post_rst_mem_edge", mem_e, r_edge + LW + 2);
    repeat (40) step(1'b1);
    $display("scenario async-reset done at cycle %0d", cyc);

    // Randomised lock activity with occasional async resets.
    for (int ep = 0; ep < 40; ep++) begin
      int hi, lo;
      hi = $urandom_range(1, 60);
      lo = $urandom_range(1, 4);
      for (int i = 0; i < hi; i++) step(1'b1);
      if ($urandom_range(0, 7) == 0) async_rst_pulse();
      for (int i = 0; i < lo; i++) step(1'b0);
    end
    $display("scenario random done at cycle %0d", cyc);

`ifdef PLL_LOSS_CNT_EN
    for (int i = 0; i < 300; i++) begin
      repeat (RUN_H + 2) step(1'b1);
      repeat (3) step(1'b0);
    end
    #1;
    check("loss_cnt_saturate", int'(loss_cnt), 255);
    $display("scenario loss-saturation done at cycle %0d", cyc);
`endif

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
